// File: rtl/core_types_pkg.sv
// Shared core sizing constants used by the front-end prediction structures.
package core_types_pkg;

  localparam int unsigned RAS_ENTRIES      = 8;
  localparam int unsigned RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES);
  localparam int unsigned RAS_TARGET_WIDTH = 31;

endpackage

// File: rtl/ras.sv
// Return address stack: circular flop array with top pointer, saturating
// occupancy count and single-cycle checkpoint restore.
module ras #(
  parameter int unsigned RAS_ENTRIES      = core_types_pkg::RAS_ENTRIES,
  parameter int unsigned RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
  parameter int unsigned RAS_TARGET_WIDTH = core_types_pkg::RAS_TARGET_WIDTH
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0]   push_target,
  input  logic                          pop_valid,
  input  logic                          restore_valid,
  input  logic [RAS_INDEX_WIDTH-1:0]    restore_index,
  input  logic [RAS_INDEX_WIDTH:0]      restore_count,
  output logic [RAS_TARGET_WIDTH-1:0]   top_target,
  output logic [RAS_INDEX_WIDTH-1:0]    top_index,
  output logic [RAS_INDEX_WIDTH:0]      count,
  output logic                          empty
);

  localparam int unsigned IW = RAS_INDEX_WIDTH;
  localparam int unsigned CW = RAS_INDEX_WIDTH + 1;
  localparam int unsigned TW = RAS_TARGET_WIDTH;
  localparam logic [CW-1:0] CNT_MAX = CW'(RAS_ENTRIES);

  logic [TW-1:0] ent_q [RAS_ENTRIES];
  logic [TW-1:0] ent_d [RAS_ENTRIES];
  logic [IW-1:0] top_q, top_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] top_inc;

  assign top_inc = top_q + IW'(1);

  // Next state: restore wins, then push+pop (replace top), push, pop.
  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    ent_d = ent_q;
    if (restore_valid) begin
      top_d = restore_index;
      cnt_d = (restore_count > CNT_MAX) ? CNT_MAX : restore_count;
    end else if (push_valid && pop_valid) begin
      ent_d[top_q] = push_target;
      if (cnt_q == '0) begin
        cnt_d = CW'(1);
      end
    end else if (push_valid) begin
      top_d        = top_inc;
      ent_d[top_inc] = push_target;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (pop_valid && (cnt_q != '0)) begin
      top_d = top_q - IW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      top_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(RAS_ENTRIES); i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < int'(RAS_ENTRIES); i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  assign top_target = ent_q[top_q];
  assign top_index  = top_q;
  assign count      = cnt_q;
  assign empty      = (cnt_q == '0);

endmodule

// File: tb/tb_ras.sv
// Self-checking bench for ras: directed scenarios plus a randomized run,
// with a reference model feeding a queue of expected post-edge states.
module tb_ras;

  localparam int NE = 8;

  logic        CLK;
  logic        RST;
  logic        push_valid;
  logic [30:0] push_target;
  logic        pop_valid;
  logic        restore_valid;
  logic [2:0]  restore_index;
  logic [3:0]  restore_count;
  logic [30:0] top_target;
  logic [2:0]  top_index;
  logic [3:0]  count;
  logic        empty;

  ras dut (
    .CLK           (CLK),
    .RST           (RST),
    .push_valid    (push_valid),
    .push_target   (push_target),
    .pop_valid     (pop_valid),
    .restore_valid (restore_valid),
    .restore_index (restore_index),
    .restore_count (restore_count),
    .top_target    (top_target),
    .top_index     (top_index),
    .count         (count),
    .empty         (empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [30:0] tt;
    logic [2:0]  ti;
    logic [3:0]  cnt;
    logic        emp;
  } exp_t;

  exp_t        sb[$];
  int          n_vec;
  int          n_err;
  logic [30:0] m_ent [NE];
  int          m_top;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_top = 0;
    m_cnt = 0;
    for (int i = 0; i < NE; i++) m_ent[i] = '0;
    sb.delete();
  endtask

  // Drive one cycle from posedge+1, check pop-cycle target, then compare after the edge.
  task automatic step(input logic pu, input logic [30:0] pt, input logic po,
                      input logic rv, input logic [2:0] ri, input logic [3:0] rc,
                      input string tag);
    exp_t e;
    push_valid    = pu;
    push_target   = pt;
    pop_valid     = po;
    restore_valid = rv;
    restore_index = ri;
    restore_count = rc;
    if (po) chk({tag, "_pre_tt"}, 32'(top_target), 32'(m_ent[m_top]));
    if (rv) begin
      m_top = int'(ri);
      m_cnt = (int'(rc) > NE) ? NE : int'(rc);
    end else if (pu && po) begin
      m_ent[m_top] = pt;
      if (m_cnt == 0) m_cnt = 1;
    end else if (pu) begin
      m_top = (m_top + 1) % NE;
      m_ent[m_top] = pt;
      if (m_cnt < NE) m_cnt = m_cnt + 1;
    end else if (po && m_cnt > 0) begin
      m_top = (m_top + NE - 1) % NE;
      m_cnt = m_cnt - 1;
    end
    e.tt  = m_ent[m_top];
    e.ti  = 3'(m_top);
    e.cnt = 4'(m_cnt);
    e.emp = (m_cnt == 0);
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_tt"},  32'(top_target), 32'(e.tt));
      chk({tag, "_ti"},  32'(top_index),  32'(e.ti));
      chk({tag, "_cnt"}, 32'(count),      32'(e.cnt));
      chk({tag, "_emp"}, 32'(empty),      32'(e.emp));
    end
    push_valid    = 1'b0;
    pop_valid     = 1'b0;
    restore_valid = 1'b0;
  endtask

  task automatic push(input logic [30:0] v, input string tag);
    step(1'b1, v, 1'b0, 1'b0, 3'd0, 4'd0, tag);
  endtask

  task automatic pop(input string tag);
    step(1'b0, 31'd0, 1'b1, 1'b0, 3'd0, 4'd0, tag);
  endtask

  initial begin
    int r;
    n_vec = 0;
    n_err = 0;
    RST = 1'b1;
    push_valid = 1'b0; push_target = '0; pop_valid = 1'b0;
    restore_valid = 1'b0; restore_index = '0; restore_count = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    #3 RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("rst_tt", 32'(top_target), 32'd0);
    chk("rst_ti", 32'(top_index), 32'd0);
    chk("rst_cnt", 32'(count), 32'd0);
    chk("rst_emp", 32'(empty), 32'd1);

    // Basic push/pop ordering.
    push(31'h1000, "p1"); push(31'h2000, "p2"); push(31'h3000, "p3");
    chk("b_tt", 32'(top_target), 32'h3000);
    chk("b_ti", 32'(top_index), 32'd3);
    chk("b_cnt", 32'(count), 32'd3);
    chk("b_pop1", 32'(top_target), 32'h3000); pop("o1");
    chk("b_pop2", 32'(top_target), 32'h2000); pop("o2");
    chk("b_pop3", 32'(top_target), 32'h1000); pop("o3");
    chk("b_cnt0", 32'(count), 32'd0);
    chk("b_emp", 32'(empty), 32'd1);

    // Overflow wrap: nine pushes into eight slots.
    for (int i = 1; i <= 9; i++) push(31'(i), "w");
    chk("w_cnt", 32'(count), 32'd8);
    chk("w_ti", 32'(top_index), 32'd1);
    chk("w_tt", 32'(top_target), 32'h9);
    for (int i = 9; i >= 2; i--) begin
      chk("w_pop", 32'(top_target), 32'(i));
      pop("wo");
    end
    chk("w_cnt0", 32'(count), 32'd0);
    pop("under");
    chk("u_ti", 32'(top_index), 32'd1);
    chk("u_cnt", 32'(count), 32'd0);

    // Replace top via push and pop together.
    push(31'h1000, "q1"); push(31'h2000, "q2");
    step(1'b1, 31'h5000, 1'b1, 1'b0, 3'd0, 4'd0, "rep");
    chk("rep_tt", 32'(top_target), 32'h5000);
    chk("rep_ti", 32'(top_index), 32'd3);
    chk("rep_cnt", 32'(count), 32'd2);

    // Asynchronous reset mid-sequence with a push held.
    push(31'h11, "a1"); push(31'h22, "a2"); push(31'h33, "a3");
    chk("a_cnt5", 32'(count), 32'd5);
    #2 RST = 1'b1;
    push_valid = 1'b1; push_target = 31'h7777;
    #1;
    chk("ar_tt", 32'(top_target), 32'd0);
    chk("ar_cnt", 32'(count), 32'd0);
    chk("ar_emp", 32'(empty), 32'd1);
    @(posedge CLK);
    #3 RST = 1'b0;
    push_valid = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    chk("ar_ti", 32'(top_index), 32'd0);
    chk("ar_cnt2", 32'(count), 32'd0);

    // Checkpoint restore with a wrong-path push/pop sequence.
    push(31'h1000, "c1"); push(31'h2000, "c2");
    push(31'hA, "cw"); pop("cp1"); pop("cp2"); pop("cp3");
    step(1'b1, 31'h7777, 1'b0, 1'b1, 3'd2, 4'd2, "rest");
    chk("r_ti", 32'(top_index), 32'd2);
    chk("r_cnt", 32'(count), 32'd2);
    chk("r_tt", 32'(top_target), 32'h2000);
    pop("rp1");
    chk("r_tt1", 32'(top_target), 32'h1000);
    step(1'b0, 31'd0, 1'b0, 1'b1, 3'd5, 4'd15, "rsat");
    chk("rsat_cnt", 32'(count), 32'd8);

    // Randomized traffic against the model.
    for (int c = 0; c < 10000; c++) begin
      r = $urandom_range(0, 99);
      step(r < 45, 31'($urandom), (r >= 30) && (r < 90), r >= 95,
           3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
